seven_seg_arbiter: RTL and testbench

- Shares the single 8-digit seven-segment display between 4 requesters.
- Each requester presents a 32-bit hex word (8 nibbles) plus a request line.
- Ownership is granted round-robin with a guaranteed minimum dwell time, so each owner's value stays readable.
- Sits between the application datapath and the seven-segment driver; its disp_data output feeds the driver's 32-bit data input.

---
 rtl/seven_seg_arbiter.sv | 145 ++++++++++++++
 tb/tb_seven_seg_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_arbiter.sv
// seven_seg_arbiter
//   Shares one 8-digit seven-segment display among 4 requesters. Ownership
//   moves round-robin, and each tenure lasts at least HOLD cycles so the
//   shown value stays readable. Every output is registered.
//
// Ports
//   clk        system clock
//   rs         asynchronous active-low reset
//   req        request line per requester (bit i = requester i)
//   req_data   requester words, requester i on [32i+31:32i]
//   gnt        one-hot grant, zero when idle
//   disp_data  word sent to the seven-segment driver
//   disp_owner index of the current owner, 0 when idle
//   disp_busy  high while a grant is held
//   sw         one-cycle pulse on every owner change (idle transitions too)
module seven_seg_arbiter #(
  parameter int          N_REQ     = 4,
  parameter int          HOLD      = 1000,
  parameter logic [31:0] BLANK_VAL = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rs,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  output logic [3:0]   gnt,
  output logic [31:0]  disp_data,
  output logic [1:0]   disp_owner,
  output logic         disp_busy,
  output logic         sw
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam int            CW      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       owner_d;
  logic [3:0]       gnt_d;
  logic [31:0]      data_d;
  logic             busy_d, sw_d;

  logic [3:0][31:0] words;
  logic [1:0]       rr_start;
  logic [1:0]       win;
  logic             win_vld;
  logic             expire, arb;

  assign words = req_data;

  // Round-robin search starts just past the previous owner. In OWN this is
  // the current owner, so it can only re-win when nobody else is asking.
  assign rr_start = (state_q == IDLE) ? 2'(last_q + 2'd1) : 2'(disp_owner + 2'd1);
  assign expire   = (state_q == OWN) && (cnt_q == CNT_MAX);
  assign arb      = (state_q == IDLE) || expire;

  // Scan from the farthest candidate to the nearest so the closest hit wins.
  always_comb begin
    logic [1:0] cand;
    win_vld = 1'b0;
    win     = 2'd0;
    cand    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = 2'(rr_start + 2'(k));
      if (req[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  // State register (outputs are registered here too)
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 2'd3;
      disp_owner <= 2'd0;
      gnt        <= 4'b0000;
      disp_data  <= BLANK_VAL;
      disp_busy  <= 1'b0;
      sw         <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      disp_owner <= owner_d;
      gnt        <= gnt_d;
      disp_data  <= data_d;
      disp_busy  <= busy_d;
      sw         <= sw_d;
    end
  end

  // Next-state: tenure bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = disp_owner;
    if (arb) begin
      cnt_d = '0;
      if (win_vld) begin
        state_d = OWN;
        last_d  = win;
        owner_d = win;
      end else begin
        state_d = IDLE;
        owner_d = 2'd0;
      end
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output values for the next cycle
  always_comb begin
    gnt_d  = gnt;
    data_d = disp_data;
    busy_d = disp_busy;
    sw_d   = 1'b0;
    if (arb) begin
      if (win_vld) begin
        gnt_d  = 4'b0001 << win;
        data_d = words[win];
        busy_d = 1'b1;
        sw_d   = (state_q == IDLE) || (win != disp_owner);
      end else begin
        gnt_d  = 4'b0000;
        data_d = BLANK_VAL;
        busy_d = 1'b0;
        sw_d   = (state_q == OWN);
      end
    end else if (req[disp_owner]) begin
      // Owner still requesting: track its word; otherwise the display freezes.
      data_d = words[disp_owner];
    end
  end

  a_gnt_shape: assert property (@(posedge clk) disable iff (!rs)
    (N_REQ == 4) && $onehot0(gnt) && (!disp_busy || (gnt != 4'b0000)));

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Randomized bench for seven_seg_arbiter. Two instances share the inputs:
// HOLD=4 and HOLD=1. A tenure-level reference model predicts each output.
module tb_seven_seg_arbiter;

  localparam logic [31:0] BLANK = 32'h0000_0000;

  logic         clk;
  logic         rs;
  logic [3:0]   req;
  logic [127:0] req_data;

  logic [1:0][3:0]  gnt_o;
  logic [1:0][31:0] data_o;
  logic [1:0][1:0]  owner_o;
  logic [1:0]       busy_o;
  logic [1:0]       sw_o;

  seven_seg_arbiter #(.N_REQ(4), .HOLD(4), .BLANK_VAL(BLANK)) u_h4 (
    .clk(clk), .rs(rs), .req(req), .req_data(req_data),
    .gnt(gnt_o[0]), .disp_data(data_o[0]), .disp_owner(owner_o[0]),
    .disp_busy(busy_o[0]), .sw(sw_o[0]));

  seven_seg_arbiter #(.N_REQ(4), .HOLD(1), .BLANK_VAL(BLANK)) u_h1 (
    .clk(clk), .rs(rs), .req(req), .req_data(req_data),
    .gnt(gnt_o[1]), .disp_data(data_o[1]), .disp_owner(owner_o[1]),
    .disp_busy(busy_o[1]), .sw(sw_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: owner index (-1 = nobody), cycles spent in tenure,
  // last winner, displayed word, and whether the last edge changed owner.
  int          holds [2] = '{4, 1};
  int          m_owner [2];
  int          m_dwell [2];
  int          m_last  [2];
  logic [31:0] m_data  [2];
  logic        m_sw    [2];

  function automatic int rr_pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_dwell[d] = 0; m_last[d] = 3;
      m_data[d] = BLANK; m_sw[d] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [127:0] wd);
    int prev, w;
    for (int d = 0; d < 2; d++) begin
      prev = m_owner[d];
      if (prev < 0 || m_dwell[d] == holds[d] - 1) begin
        w = rr_pick(r, (prev < 0) ? m_last[d] + 1 : prev + 1);
        if (w < 0) begin
          m_owner[d] = -1; m_dwell[d] = 0; m_data[d] = BLANK;
        end else begin
          m_owner[d] = w; m_dwell[d] = 0; m_last[d] = w;
          m_data[d] = wd[w*32 +: 32];
        end
      end else begin
        m_dwell[d]++;
        if (r[prev]) m_data[d] = wd[prev*32 +: 32];
      end
      m_sw[d] = (m_owner[d] != prev);
    end
  endtask

  task automatic check_all(input string ph);
    logic [3:0] eg;
    logic [1:0] eo;
    for (int d = 0; d < 2; d++) begin
      eg = (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
      eo = (m_owner[d] < 0) ? 2'd0 : 2'(m_owner[d]);
      chk($sformatf("%s d%0d gnt", ph, d),   32'(gnt_o[d]),   32'(eg));
      chk($sformatf("%s d%0d data", ph, d),  data_o[d],       m_data[d]);
      chk($sformatf("%s d%0d owner", ph, d), 32'(owner_o[d]), 32'(eo));
      chk($sformatf("%s d%0d busy", ph, d),  32'(busy_o[d]),  32'(m_owner[d] >= 0));
      chk($sformatf("%s d%0d sw", ph, d),    32'(sw_o[d]),    32'(m_sw[d]));
    end
  endtask

  // Apply inputs, let one edge happen, update model, check 1 time unit later.
  task automatic cycle(input string ph, input logic [3:0] r, input logic [127:0] wd);
    req = r; req_data = wd;
    @(posedge clk);
    model_step(r, wd);
    #1;
    check_all(ph);
  endtask

  function automatic logic [127:0] rnd_words();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] STEP_WORDS = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

  initial begin
    rs = 1'b0; req = 4'b0000; req_data = '0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #2; rs = 1'b1;

    // First grant from idle goes to the only requester, one edge later.
    cycle("first", 4'b0100, rnd_words());
    chk("first gnt const", 32'(gnt_o[0]), 32'h4);
    chk("first data const", data_o[0], req_data[95:64]);
    for (int i = 0; i < 4; i++) cycle("idle1", 4'b0000, rnd_words());

    // Everybody requesting continuously.
    for (int i = 0; i < 20; i++) cycle("all", 4'b1111, STEP_WORDS);
    for (int i = 0; i < 5; i++) cycle("idle2", 4'b0000, rnd_words());

    // Owner 1 drops after one cycle while its word keeps changing.
    cycle("drop", 4'b0010, rnd_words());
    for (int i = 0; i < 5; i++) cycle("drop", 4'b0000, rnd_words());

    // Sole requester keeps the grant across expiries.
    for (int i = 0; i < 12; i++) cycle("sole", 4'b0001, rnd_words());
    for (int i = 0; i < 5; i++) cycle("idle3", 4'b0000, rnd_words());

    // Late arrival waits for expiry, then wins over the still-asking owner.
    cycle("late", 4'b0001, rnd_words());
    for (int i = 0; i < 8; i++) cycle("late", 4'b1001, rnd_words());
    for (int i = 0; i < 5; i++) cycle("idle4", 4'b0000, rnd_words());

    // Random traffic with sticky request patterns.
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        cycle("rand", r, rnd_words());
      end
    end
    for (int i = 0; i < 5; i++) cycle("idle5", 4'b0000, rnd_words());

    // Reset in the middle of owner 2's tenure, then restart with all asking.
    cycle("pre_rst", 4'b0100, rnd_words());
    cycle("pre_rst", 4'b0100, rnd_words());
    #2; rs = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #1; rs = 1'b1;
    for (int i = 0; i < 10; i++) cycle("post_rst", 4'b1111, rnd_words());
    chk("post_rst owner0 first", 32'(m_last[0] >= 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
